// File: rtl/conversor_bcd_pkg.sv
// Shared definitions for the binary-to-BCD display converter: FSM encoding,
// iteration counts, 7-segment patterns (gfedcba) and double-dabble helpers.
package conversor_bcd_pkg;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    CONV_VALOR = 2'd1,
    CONV_RESTO = 2'd2,
    ATUALIZA   = 2'd3
  } estado_t;

  localparam logic [4:0] N_ITER_VALOR = 5'd16;
  localparam logic [4:0] N_ITER_RESTO = 5'd8;

  localparam logic [6:0] SEG_0       = 7'h3F;
  localparam logic [6:0] SEG_1       = 7'h06;
  localparam logic [6:0] SEG_2       = 7'h5B;
  localparam logic [6:0] SEG_3       = 7'h4F;
  localparam logic [6:0] SEG_4       = 7'h66;
  localparam logic [6:0] SEG_5       = 7'h6D;
  localparam logic [6:0] SEG_6       = 7'h7D;
  localparam logic [6:0] SEG_7       = 7'h07;
  localparam logic [6:0] SEG_8       = 7'h7F;
  localparam logic [6:0] SEG_9       = 7'h6F;
  localparam logic [6:0] SEG_APAGADO = 7'h00;

  // Digits >= 5 get +3 so the following shift carries correctly into the next digit.
  function automatic logic [3:0] soma3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic [19:0] ajusta20(input logic [19:0] a);
    logic [19:0] r;
    r = 20'd0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = soma3(a[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic [11:0] ajusta12(input logic [11:0] a);
    logic [11:0] r;
    r = 12'd0;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = soma3(a[4*i +: 4]);
    end
    return r;
  endfunction

endpackage

// File: rtl/conversor_bcd_decod7seg.sv
// Combinational BCD digit to 7-segment (gfedcba) decoder with blanking and
// selectable segment polarity.
module decod7seg
  import conversor_bcd_pkg::*;
#(
  parameter bit ANODO_COMUM = 1'b0
) (
  input  logic [3:0] digito,
  input  logic       apagado,
  output logic [6:0] segs
);

  logic [6:0] raw_s;

  // Pattern lookup; codes 10-15 never occur and show blank.
  always_comb begin
    raw_s = SEG_APAGADO;
    if (apagado) begin
      raw_s = SEG_APAGADO;
    end else begin
      case (digito)
        4'd0:    raw_s = SEG_0;
        4'd1:    raw_s = SEG_1;
        4'd2:    raw_s = SEG_2;
        4'd3:    raw_s = SEG_3;
        4'd4:    raw_s = SEG_4;
        4'd5:    raw_s = SEG_5;
        4'd6:    raw_s = SEG_6;
        4'd7:    raw_s = SEG_7;
        4'd8:    raw_s = SEG_8;
        4'd9:    raw_s = SEG_9;
        default: raw_s = SEG_APAGADO;
      endcase
    end
  end

  assign segs = ANODO_COMUM ? ~raw_s : raw_s;

endmodule

// File: rtl/conversor_bcd.sv
// Sequential double-dabble converter: Valor (16 bits) and Resto (8 bits) to BCD,
// then registered 7-segment fields with leading-zero blanking.
module conversor_bcd
  import conversor_bcd_pkg::*;
#(
  parameter bit ANODO_COMUM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Inicio,
  input  logic [15:0] Valor,
  input  logic [7:0]  Resto,
  output logic        Ocupado,
  output logic        Pronto,
  output logic [19:0] Digitos,
  output logic [11:0] DigResto,
  output logic [55:0] Hex
);

  localparam logic [6:0] SEG_OFF     = ANODO_COMUM ? 7'h7F : 7'h00;
  localparam logic [4:0] ULT_VALOR   = N_ITER_VALOR - 5'd1;
  localparam logic [4:0] ULT_RESTO   = N_ITER_RESTO - 5'd1;

  estado_t     estado_r, prox_estado_s;
  logic [15:0] sh_valor_r;
  logic [7:0]  sh_resto_r;
  logic [19:0] acc_valor_r, adj_valor_s;
  logic [11:0] acc_resto_r, adj_resto_s;
  logic [4:0]  cnt_r;
  logic        ocupado_r, pronto_r;
  logic [19:0] digitos_r;
  logic [11:0] dig_resto_r;
  logic [55:0] hex_r, hex_s;
  logic [3:0]  dig_s [8];
  logic [7:0]  blank_s;
  logic [4:0]  zv_s;
  logic [2:0]  zr_s;

  assign adj_valor_s = ajusta20(acc_valor_r);
  assign adj_resto_s = ajusta12(acc_resto_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r <= OCIOSO;
    end else begin
      estado_r <= prox_estado_s;
    end
  end

  // Next-state logic.
  always_comb begin
    prox_estado_s = estado_r;
    case (estado_r)
      OCIOSO: begin
        if (Inicio) begin
          prox_estado_s = CONV_VALOR;
        end else begin
          prox_estado_s = OCIOSO;
        end
      end
      CONV_VALOR: begin
        if (cnt_r == ULT_VALOR) begin
          prox_estado_s = CONV_RESTO;
        end else begin
          prox_estado_s = CONV_VALOR;
        end
      end
      CONV_RESTO: begin
        if (cnt_r == ULT_RESTO) begin
          prox_estado_s = ATUALIZA;
        end else begin
          prox_estado_s = CONV_RESTO;
        end
      end
      ATUALIZA: prox_estado_s = OCIOSO;
      default:  prox_estado_s = OCIOSO;
    endcase
  end

  // Capture, shift-add-3 iterations and output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_valor_r  <= 16'd0;
      sh_resto_r  <= 8'd0;
      acc_valor_r <= 20'd0;
      acc_resto_r <= 12'd0;
      cnt_r       <= 5'd0;
      ocupado_r   <= 1'b0;
      pronto_r    <= 1'b0;
      digitos_r   <= 20'd0;
      dig_resto_r <= 12'd0;
      hex_r       <= {8{SEG_OFF}};
    end else begin
      case (estado_r)
        OCIOSO: begin
          pronto_r <= 1'b0;
          if (Inicio) begin
            sh_valor_r  <= Valor;
            sh_resto_r  <= Resto;
            acc_valor_r <= 20'd0;
            acc_resto_r <= 12'd0;
            cnt_r       <= 5'd0;
            ocupado_r   <= 1'b1;
          end
        end
        CONV_VALOR: begin
          pronto_r    <= 1'b0;
          acc_valor_r <= (adj_valor_s << 1) | {19'd0, sh_valor_r[15]};
          sh_valor_r  <= {sh_valor_r[14:0], 1'b0};
          cnt_r       <= (cnt_r == ULT_VALOR) ? 5'd0 : cnt_r + 5'd1;
        end
        CONV_RESTO: begin
          pronto_r    <= 1'b0;
          acc_resto_r <= (adj_resto_s << 1) | {11'd0, sh_resto_r[7]};
          sh_resto_r  <= {sh_resto_r[6:0], 1'b0};
          cnt_r       <= (cnt_r == ULT_RESTO) ? 5'd0 : cnt_r + 5'd1;
        end
        ATUALIZA: begin
          digitos_r   <= acc_valor_r;
          dig_resto_r <= acc_resto_r;
          hex_r       <= hex_s;
          pronto_r    <= 1'b1;
          ocupado_r   <= 1'b0;
          cnt_r       <= 5'd0;
        end
        default: begin
          pronto_r  <= 1'b0;
          ocupado_r <= 1'b0;
          cnt_r     <= 5'd0;
        end
      endcase
    end
  end

  // Digit selection and leading-zero blanking; units fields are never blanked.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      dig_s[i] = acc_valor_r[4*i +: 4];
      zv_s[i]  = (acc_valor_r[4*i +: 4] == 4'd0);
    end
    for (int i = 0; i < 3; i++) begin
      dig_s[5+i] = acc_resto_r[4*i +: 4];
      zr_s[i]    = (acc_resto_r[4*i +: 4] == 4'd0);
    end
    blank_s[0] = 1'b0;
    blank_s[1] = zv_s[4] & zv_s[3] & zv_s[2] & zv_s[1];
    blank_s[2] = zv_s[4] & zv_s[3] & zv_s[2];
    blank_s[3] = zv_s[4] & zv_s[3];
    blank_s[4] = zv_s[4];
    blank_s[5] = 1'b0;
    blank_s[6] = zr_s[2] & zr_s[1];
    blank_s[7] = zr_s[2];
  end

  for (genvar g = 0; g < 8; g++) begin : g_dec
    decod7seg #(
      .ANODO_COMUM (ANODO_COMUM)
    ) u_dec (
      .digito  (dig_s[g]),
      .apagado (blank_s[g]),
      .segs    (hex_s[7*g +: 7])
    );
  end

  assign Ocupado  = ocupado_r;
  assign Pronto   = pronto_r;
  assign Digitos  = digitos_r;
  assign DigResto = dig_resto_r;
  assign Hex      = hex_r;

endmodule

// File: tb/tb_conversor_bcd.sv
// Directed bench: two converters (both polarities) share stimulus; expected
// digits and segment fields are hand-computed constants.
module tb_conversor_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inicio;
  logic [15:0] valor;
  logic [7:0]  resto;

  logic        ocupado_a, pronto_a, ocupado_b, pronto_b;
  logic [19:0] digitos_a, digitos_b;
  logic [11:0] digres_a, digres_b;
  logic [55:0] hex_a, hex_b;

  int total = 0;
  int bad   = 0;

  localparam logic [55:0] ALL_ON = 56'hFF_FFFF_FFFF_FFFF;

  // Vectors: 0/0, max, 1234/56, inner zeros, all remaining digit codes.
  localparam logic [15:0] TV_VALOR [5] = '{16'd0, 16'd65535, 16'd1234, 16'd10203, 16'd59876};
  localparam logic [7:0]  TV_RESTO [5] = '{8'd0, 8'd255, 8'd56, 8'd7, 8'd140};
  localparam logic [19:0] TV_DIG   [5] = '{20'h00000, 20'h65535, 20'h01234, 20'h10203, 20'h59876};
  localparam logic [11:0] TV_RES   [5] = '{12'h000, 12'h255, 12'h056, 12'h007, 12'h140};
  localparam logic [55:0] TV_HEX   [5] = '{
    {7'h00, 7'h00, 7'h3F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F},
    {7'h5B, 7'h6D, 7'h6D, 7'h7D, 7'h6D, 7'h6D, 7'h4F, 7'h6D},
    {7'h00, 7'h6D, 7'h7D, 7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66},
    {7'h00, 7'h00, 7'h07, 7'h06, 7'h3F, 7'h5B, 7'h3F, 7'h4F},
    {7'h06, 7'h66, 7'h3F, 7'h6D, 7'h6F, 7'h7F, 7'h07, 7'h7D}
  };

  conversor_bcd u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .Inicio   (inicio),
    .Valor    (valor),
    .Resto    (resto),
    .Ocupado  (ocupado_a),
    .Pronto   (pronto_a),
    .Digitos  (digitos_a),
    .DigResto (digres_a),
    .Hex      (hex_a)
  );

  conversor_bcd #(.ANODO_COMUM(1'b1)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .Inicio   (inicio),
    .Valor    (valor),
    .Resto    (resto),
    .Ocupado  (ocupado_b),
    .Pronto   (pronto_b),
    .Digitos  (digitos_b),
    .DigResto (digres_b),
    .Hex      (hex_b)
  );

  always #5 clk = ~clk;

  // One-cycle Inicio pulse; returns at the falling edge right after capture.
  task automatic start_conv(input logic [15:0] v, input logic [7:0] r);
    @(negedge clk);
    valor  = v;
    resto  = r;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    inicio = 1'b0;
    valor  = 16'd0;
    resto  = 8'd0;
    repeat (3) @(negedge clk);
    total++;
    if (ocupado_a !== 1'b0 || pronto_a !== 1'b0 || digitos_a !== 20'd0 || digres_a !== 12'd0
        || hex_a !== 56'd0 || hex_b !== ALL_ON || ocupado_b !== 1'b0 || pronto_b !== 1'b0) begin
      bad++;
      $display("FAIL reset: ocup=%b pronto=%b dig=%h res=%h hexa=%h hexb=%h, expected 0 0 0 0 0 all-ones",
               ocupado_a, pronto_a, digitos_a, digres_a, hex_a, hex_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [19:0] prev_dig = 20'd0;
    logic [55:0] prev_hex = 56'd0;
    for (int v = 0; v < 5; v++) begin
      int  lat = 0;
      bit  hold_bad = 1'b0;
      start_conv(TV_VALOR[v], TV_RESTO[v]);
      total++;
      if (ocupado_a !== 1'b1 || ocupado_b !== 1'b1) begin
        bad++;
        $display("FAIL busy[%0d]: ocupado=%b/%b, expected 1", v, ocupado_a, ocupado_b);
      end
      for (int i = 1; i <= 40 && lat == 0; i++) begin
        @(negedge clk);
        if (pronto_a === 1'b1) begin
          lat = i;
        end else if (digitos_a !== prev_dig || hex_a !== prev_hex || ocupado_a !== 1'b1) begin
          hold_bad = 1'b1;
        end
      end
      total++;
      if (hold_bad) begin
        bad++;
        $display("FAIL hold[%0d]: outputs changed or Ocupado dropped before Pronto, expected dig=%h held", v, prev_dig);
      end
      total++;
      if (lat !== 25 || pronto_b !== 1'b1 || ocupado_a !== 1'b0) begin
        bad++;
        $display("FAIL latency[%0d]: pronto at %0d (b=%b ocup=%b), expected 25 (1 0)", v, lat, pronto_b, ocupado_a);
      end
      total++;
      if (digitos_a !== TV_DIG[v] || digres_a !== TV_RES[v] || digitos_b !== TV_DIG[v] || digres_b !== TV_RES[v]) begin
        bad++;
        $display("FAIL digits[%0d]: dig=%h res=%h, expected %h %h", v, digitos_a, digres_a, TV_DIG[v], TV_RES[v]);
      end
      total++;
      if (hex_a !== TV_HEX[v] || hex_b !== ~TV_HEX[v]) begin
        bad++;
        $display("FAIL hex[%0d]: a=%h b=%h, expected a=%h b=%h", v, hex_a, hex_b, TV_HEX[v], ~TV_HEX[v]);
      end
      @(negedge clk);
      total++;
      if (pronto_a !== 1'b0 || pronto_b !== 1'b0) begin
        bad++;
        $display("FAIL pulse[%0d]: pronto=%b/%b one cycle later, expected 0", v, pronto_a, pronto_b);
      end
      prev_dig = TV_DIG[v];
      prev_hex = TV_HEX[v];
    end
  endtask

  task automatic test_ignore_inicio();
    int n_pronto = 0;
    int first_at = 0;
    start_conv(16'd1234, 8'd56);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (pronto_a === 1'b1) begin
        n_pronto++;
        if (first_at == 0) first_at = i;
      end
      if (i == 3 || i == 20) begin
        inicio = 1'b1;
        valor  = 16'd4321;
        resto  = 8'd99;
      end else begin
        inicio = 1'b0;
      end
    end
    total++;
    if (n_pronto !== 1 || first_at !== 25) begin
      bad++;
      $display("FAIL ignore_pronto: %0d pulses first at %0d, expected 1 at 25", n_pronto, first_at);
    end
    total++;
    if (digitos_a !== 20'h01234 || digres_a !== 12'h056) begin
      bad++;
      $display("FAIL ignore_result: dig=%h res=%h, expected 01234 056", digitos_a, digres_a);
    end
  endtask

  task automatic test_mid_reset();
    int n_pronto = 0;
    int lat = 0;
    start_conv(16'd65535, 8'd255);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (ocupado_a !== 1'b0 || ocupado_b !== 1'b0 || hex_a !== 56'd0 || hex_b !== ALL_ON
        || digitos_a !== 20'd0 || digres_a !== 12'd0) begin
      bad++;
      $display("FAIL abort: ocup=%b/%b hexa=%h hexb=%h dig=%h res=%h, expected 0 0 0 all-ones 0 0",
               ocupado_a, ocupado_b, hex_a, hex_b, digitos_a, digres_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pronto_a === 1'b1 || pronto_b === 1'b1) n_pronto++;
    end
    total++;
    if (n_pronto !== 0) begin
      bad++;
      $display("FAIL abort_pronto: %0d pulses after aborted conversion, expected 0", n_pronto);
    end
    start_conv(16'd10203, 8'd7);
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (pronto_a === 1'b1) lat = i;
    end
    total++;
    if (lat !== 25 || digitos_a !== 20'h10203 || digres_a !== 12'h007 || hex_a !== TV_HEX[3]) begin
      bad++;
      $display("FAIL after_reset: lat=%0d dig=%h res=%h hex=%h, expected 25 10203 007 %h",
               lat, digitos_a, digres_a, hex_a, TV_HEX[3]);
    end
  endtask

  task automatic test_back_to_back();
    int p1 = 0;
    int p2 = 0;
    @(negedge clk);
    valor  = 16'd1234;
    resto  = 8'd56;
    inicio = 1'b1;
    @(negedge clk);
    valor  = 16'd65535;
    resto  = 8'd255;
    for (int i = 1; i <= 70 && p2 == 0; i++) begin
      @(negedge clk);
      if (pronto_a === 1'b1 && p1 == 0) begin
        p1 = i;
        total++;
        if (digitos_a !== 20'h01234 || hex_a !== TV_HEX[2] || hex_b !== ~TV_HEX[2]) begin
          bad++;
          $display("FAIL b2b_first: dig=%h hexa=%h hexb=%h, expected 01234 %h %h",
                   digitos_a, hex_a, hex_b, TV_HEX[2], ~TV_HEX[2]);
        end
      end else if (pronto_a === 1'b1) begin
        p2 = i;
        inicio = 1'b0;
      end
    end
    inicio = 1'b0;
    total++;
    if (p1 !== 25 || p2 - p1 !== 26) begin
      bad++;
      $display("FAIL b2b_spacing: pronto at %0d and %0d, expected 25 and 51", p1, p2);
    end
    total++;
    if (digitos_a !== 20'h65535 || digres_a !== 12'h255 || hex_a !== TV_HEX[1] || hex_b !== ~TV_HEX[1]) begin
      bad++;
      $display("FAIL b2b_second: dig=%h res=%h hexa=%h hexb=%h, expected 65535 255 %h %h",
               digitos_a, digres_a, hex_a, hex_b, TV_HEX[1], ~TV_HEX[1]);
    end
    repeat (3) @(negedge clk);
    total++;
    if (ocupado_a !== 1'b0 || pronto_a !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: ocup=%b pronto=%b after Inicio dropped, expected 0 0", ocupado_a, pronto_a);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_inicio();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conversor_bcd.md
CONVERSOR_BCD -- requirements
Module: conversor_bcd

Interface
REQ-001 Parameter ANODO_COMUM, default 0: segment polarity; 0 = segment on is 1, 1 = all segment outputs inverted.
REQ-002 clk  input  1  sole clock; every flop SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Inicio  input  1  start request, sampled only in OCIOSO.
REQ-005 Valor  input  16  unsigned result word (sum/difference/product/quotient) from the arithmetic datapath.
REQ-006 Resto  input  8  unsigned remainder from the divider; 0 for non-division operations.
REQ-007 Ocupado  output  1  high while a conversion is in progress.
REQ-008 Pronto  output  1  one-cycle pulse marking that the display outputs have been updated.
REQ-009 Digitos  output  20  five BCD digits of Valor; [19:16] is ten-thousands, [3:0] is units.
REQ-010 DigResto  output  12  three BCD digits of Resto; [11:8] is hundreds.
REQ-011 Hex  output  56  eight 7-segment fields, 7 bits each, ordered gfedcba; Hex[6:0] = Valor units, Hex[34:28] = Valor ten-thousands, Hex[41:35] = Resto units, Hex[55:49] = Resto hundreds.

Function
REQ-012 FSM states SHALL be OCIOSO, CONV_VALOR, CONV_RESTO and ATUALIZA.
REQ-013 OCIOSO with Inicio=1 SHALL capture Valor and Resto into shift registers, clear the BCD accumulators, set Ocupado=1 and move to CONV_VALOR on the same edge.
REQ-014 CONV_VALOR SHALL run 16 shift-add-3 (double-dabble) iterations, one per clock, then move to CONV_RESTO.
REQ-015 In each iteration, every 4-bit accumulator digit >= 5 SHALL get +3 before the 1-bit left shift.
REQ-016 CONV_RESTO SHALL run 8 shift-add-3 iterations on Resto using a separate 12-bit accumulator, then move to ATUALIZA.
REQ-017 A 5-bit iteration counter SHALL track iterations; it resets to 0 on every state entry.
REQ-018 ATUALIZA SHALL load Digitos, DigResto and Hex, set Pronto=1 for exactly that one cycle, set Ocupado=0 and return to OCIOSO.
REQ-019 Latency: with capture at edge k, Pronto SHALL be high in the cycle after edge k+25, and Ocupado SHALL be high from edge k to edge k+25.
REQ-020 Digitos, DigResto and Hex SHALL hold their previous values during a conversion.
REQ-021 Inicio while Ocupado=1 SHALL be ignored and not queued.
REQ-022 Inicio=1 in the first OCIOSO cycle after Pronto SHALL start a new conversion with no extra idle cycle.
REQ-023 Leading-zero blanking SHALL apply:
- A Valor field SHALL be blank (all segments off) when it and all higher Valor digits are 0.
- The Valor units field SHALL always be shown.
- The same rule SHALL apply to Resto, whose units field SHALL always be shown.
REQ-024 Digit codes 0-9 SHALL use the standard 7-segment patterns; codes 10-15 cannot occur and SHALL display blank.
REQ-025 The maximum inputs, Valor=65535 and Resto=255, SHALL convert with no overflow; accumulator widths are 20 and 12 bits.

Reset
REQ-026 rst_n=0 SHALL immediately force:
- state = OCIOSO
- Ocupado = 0, Pronto = 0
- Digitos = 0, DigResto = 0
- every Hex field blank (all segments off at the configured polarity)
- shift registers, accumulators and counter = 0
REQ-027 Reset asserted mid-conversion SHALL abort it; outputs SHALL NOT be updated by the aborted conversion.
REQ-028 After rst_n deasserts, the first Inicio SHALL be accepted on the next rising edge.

Structure
REQ-029 A shared include file SHALL hold the state encodings (2-bit), the iteration counts 16 and 8, and the ten segment pattern constants.
REQ-030 A sub-module decod7seg SHALL implement the combinational translation from a 4-bit digit plus a blank flag to 7 segments, including polarity per ANODO_COMUM.
REQ-031 conversor_bcd SHALL instantiate decod7seg eight times and register its outputs into Hex in ATUALIZA.

Verification
REQ-032 Valor=0, Resto=0, Inicio pulse -> Pronto 25 cycles after capture; Digitos=0x00000, DigResto=0x000; only Hex[6:0] and Hex[41:35] show "0", all other fields blank.
REQ-033 Valor=65535, Resto=255 -> Digitos=0x65535, DigResto=0x255; all eight fields lit.
REQ-034 Valor=1234, Resto=56 -> Digitos=0x01234, DigResto=0x056; Valor ten-thousands field and Resto hundreds field blank.
REQ-035 Inicio re-pulsed at cycles 3 and 20 of a conversion -> exactly one Pronto; result reflects the first capture only.
REQ-036 rst_n pulsed low at cycle 10 of a conversion -> Ocupado=0 immediately, all Hex fields blank, no Pronto; a fresh Inicio then completes normally.
REQ-037 Inicio held high across Pronto, with ANODO_COMUM=1 -> back-to-back conversions exactly 26 cycles apart; every segment bit is the inverse of the ANODO_COMUM=0 run.
